// File: rtl/dpi_stream_sequencer_if.sv
// Handshake bundle between the packet/byte source, config port,
// regex matcher and result sink of the stream sequencer.
interface dpi_stream_sequencer_if #(
  parameter int NSTREAM = 64
);
  localparam int IDW = $clog2(NSTREAM);

  logic           pkt_vld;
  logic           pkt_rdy;
  logic [IDW-1:0] pkt_stream_id;

  logic [7:0]     s_data;
  logic           s_vld;
  logic           s_last;
  logic           s_rdy;

  logic           cfg_we;
  logic           cfg_clr;
  logic [IDW-1:0] cfg_id;
  logic           cfg_en;

  logic           m_load_state;
  logic           m_new_stream_id;
  logic [IDW-1:0] m_stream_id;
  logic           m_enable;
  logic [7:0]     m_char_in;
  logic           m_char_in_vld;
  logic           m_eop;
  logic           m_fired;

  logic           res_vld;
  logic           res_rdy;
  logic [IDW-1:0] res_stream_id;
  logic           res_fired;

  logic [15:0]    pkt_cnt;

  modport master (
    output pkt_vld, pkt_stream_id,
    output s_data, s_vld, s_last,
    output cfg_we, cfg_clr, cfg_id, cfg_en,
    output m_fired, res_rdy,
    input  pkt_rdy, s_rdy,
    input  m_load_state, m_new_stream_id,
    input  m_stream_id, m_enable,
    input  m_char_in, m_char_in_vld, m_eop,
    input  res_vld, res_stream_id, res_fired,
    input  pkt_cnt
  );

  modport slave (
    input  pkt_vld, pkt_stream_id,
    input  s_data, s_vld, s_last,
    input  cfg_we, cfg_clr, cfg_id, cfg_en,
    input  m_fired, res_rdy,
    output pkt_rdy, s_rdy,
    output m_load_state, m_new_stream_id,
    output m_stream_id, m_enable,
    output m_char_in, m_char_in_vld, m_eop,
    output res_vld, res_stream_id, res_fired,
    output pkt_cnt
  );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Drives load/stream/drain/eop phases of one shared regex matcher
// and returns one fired/not-fired result per packet.
module dpi_stream_sequencer #(
  parameter int MATCH_LAT = 2,
  parameter int NSTREAM   = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  dpi_stream_sequencer_if.slave bus
);
  localparam int IDW = $clog2(NSTREAM);
  localparam int DW  = (MATCH_LAT < 2) ? 1 : $clog2(MATCH_LAT);
  localparam logic [DW-1:0] DLAST =
    DW'((MATCH_LAT < 1) ? 0 : MATCH_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, STREAM, DRAIN, EOP, RESULT
  } state_t;

  state_t state, state_nxt;

  logic [NSTREAM-1:0] seen;
  logic [NSTREAM-1:0] en;
  logic [IDW-1:0]     id_q;
  logic               en_q;
  logic               new_q;
  logic               fired_q;
  logic [DW-1:0]      dcnt;
  logic [15:0]        cnt;
  logic               acc;
  logic               last;

  assign acc  = bus.pkt_vld & bus.pkt_rdy;
  assign last = bus.m_char_in_vld & bus.s_last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  state_nxt = STREAM;
      STREAM:  if (last)
                 state_nxt = (MATCH_LAT == 0) ? EOP : DRAIN;
      DRAIN:   if (dcnt == DLAST) state_nxt = EOP;
      EOP:     state_nxt = RESULT;
      RESULT:  if (bus.res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pkt_rdy is gated so every output reads zero while reset is held
  assign bus.pkt_rdy         = rst_n & (state == IDLE);
  assign bus.s_rdy           = (state == STREAM);
  assign bus.m_char_in_vld   = bus.s_vld & bus.s_rdy;
  assign bus.m_char_in       = bus.s_rdy ? bus.s_data : 8'h00;
  assign bus.m_load_state    = (state == LOAD);
  assign bus.m_new_stream_id = (state == LOAD) & new_q;
  assign bus.m_stream_id     = id_q;
  assign bus.m_enable        = en_q;
  assign bus.m_eop           = (state == EOP);
  assign bus.res_vld         = (state == RESULT);
  assign bus.res_stream_id   = id_q;
  assign bus.res_fired       = fired_q;
  assign bus.pkt_cnt         = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      seen    <= '0;
      en      <= '0;
      id_q    <= '0;
      en_q    <= 1'b0;
      new_q   <= 1'b0;
      fired_q <= 1'b0;
      dcnt    <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= (state == DRAIN) ? dcnt + DW'(1) : '0;
      if (acc) begin
        id_q  <= bus.pkt_stream_id;
        en_q  <= en[bus.pkt_stream_id];
        new_q <= ~seen[bus.pkt_stream_id];
      end
      if (state == EOP) begin
        fired_q <= bus.m_fired;
        cnt     <= cnt + 16'd1;
        if (en_q) seen[id_q] <= 1'b1;
      end
      if (bus.cfg_we) en[bus.cfg_id] <= bus.cfg_en;
      // later assignment: a clear beats the EOP set on the same id
      if (bus.cfg_clr) seen[bus.cfg_id] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Table-driven packet bench with a result scoreboard for
// dpi_stream_sequencer.
module tb_dpi_stream_sequencer;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpi_stream_sequencer_if bus ();

  dpi_stream_sequencer #(.MATCH_LAT(ML), .NSTREAM(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0] pre;
    logic       pre_en;
    logic [5:0] id;
    int         len;
    logic       fired;
    int         bp;
    logic       clr_eop;
    logic       mid_we;
    logic       mid_en;
    logic       exp_new;
    logic       exp_en;
  } vec_t;

  typedef struct {
    logic [5:0] id;
    logic       fired;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cnt_m = 16'd0;
  vec_t        tv[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pkt_rdy"}, bus.pkt_rdy, 0);
    chk({tag, "_s_rdy"}, bus.s_rdy, 0);
    chk({tag, "_load"}, bus.m_load_state, 0);
    chk({tag, "_new"}, bus.m_new_stream_id, 0);
    chk({tag, "_m_id"}, bus.m_stream_id, 0);
    chk({tag, "_m_en"}, bus.m_enable, 0);
    chk({tag, "_char"}, {bus.m_char_in_vld, bus.m_char_in}, 0);
    chk({tag, "_eop"}, bus.m_eop, 0);
    chk({tag, "_res"}, {bus.res_vld, bus.res_fired, bus.res_stream_id}, 0);
    chk({tag, "_cnt"}, bus.pkt_cnt, 0);
  endtask

  task automatic run_pkt(input vec_t v);
    int   n;
    exp_t e;
    logic [7:0] b;
    if (v.pre != 2'd0) begin
      bus.cfg_id  = v.id;
      bus.cfg_en  = v.pre_en;
      bus.cfg_we  = v.pre[0];
      bus.cfg_clr = v.pre[1];
      @(negedge clk);
      bus.cfg_we  = 1'b0;
      bus.cfg_clr = 1'b0;
    end
    bus.pkt_vld       = 1'b1;
    bus.pkt_stream_id = v.id;
    n = 0;
    while (!bus.pkt_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_rdy_wait", n < 20, 1);
    e.id = v.id;
    e.fired = v.fired;
    sb.push_back(e);
    @(negedge clk);
    bus.pkt_vld = 1'b0;
    chk("load_state", bus.m_load_state, 1);
    chk("new_stream", bus.m_new_stream_id, v.exp_new);
    chk("m_stream_id", bus.m_stream_id, v.id);
    chk("m_enable", bus.m_enable, v.exp_en);
    bus.s_vld  = 1'b1;
    bus.s_data = 8'h61;
    bus.s_last = (v.len == 1);
    @(negedge clk);
    chk("settle_s_rdy", bus.s_rdy, 0);
    chk("settle_vld", bus.m_char_in_vld, 0);
    chk("settle_load", bus.m_load_state, 0);
    if (v.mid_we) begin
      bus.cfg_we = 1'b1;
      bus.cfg_id = v.id;
      bus.cfg_en = v.mid_en;
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      b = 8'h61 + 8'(i);
      bus.s_data = b;
      bus.s_last = (i == v.len - 1);
      #1;
      chk("char_vld", bus.m_char_in_vld, 1);
      chk("char_in", bus.m_char_in, b);
      @(negedge clk);
    end
    bus.s_vld   = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_fired = ~v.fired;
    n = 1;
    while (!bus.m_eop && n <= ML + 5) begin
      chk("drain_vld", bus.m_char_in_vld, 0);
      @(negedge clk);
      n++;
    end
    chk("eop_latency", n, ML + 1);
    chk("eop_enable", bus.m_enable, v.exp_en);
    bus.m_fired = v.fired;
    cnt_m = cnt_m + 16'd1;
    if (v.clr_eop) begin
      bus.cfg_clr = 1'b1;
      bus.cfg_id  = v.id;
    end
    @(negedge clk);
    bus.cfg_clr = 1'b0;
    bus.m_fired = ~v.fired;
    chk("eop_pulse", bus.m_eop, 0);
    for (int k = 0; k < v.bp; k++) begin
      chk("bp_res_vld", bus.res_vld, 1);
      chk("bp_pkt_rdy", bus.pkt_rdy, 0);
      chk("bp_res_id", bus.res_stream_id, v.id);
      chk("bp_res_fired", bus.res_fired, v.fired);
      @(negedge clk);
    end
    chk("res_vld", bus.res_vld, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("res_stream_id", bus.res_stream_id, e.id);
      chk("res_fired", bus.res_fired, e.fired);
    end
    chk("pkt_cnt", bus.pkt_cnt, cnt_m);
    bus.res_rdy = 1'b1;
    @(negedge clk);
    bus.res_rdy = 1'b0;
    bus.m_fired = 1'b0;
    chk("res_done", bus.res_vld, 0);
    chk("idle_pkt_rdy", bus.pkt_rdy, 1);
  endtask

  initial begin
    vec_t r;
    //        pre  pe  id  len f  bp  clr mw  me  new en
    tv[0]  = '{2'd1, 1, 5, 2, 0, 0, 0, 0, 0, 1, 1};
    tv[1]  = '{2'd0, 0, 5, 3, 1, 10, 0, 0, 0, 0, 1};
    tv[2]  = '{2'd0, 0, 9, 1, 1, 0, 0, 1, 1, 1, 0};
    tv[3]  = '{2'd0, 0, 9, 2, 0, 2, 0, 0, 0, 1, 1};
    tv[4]  = '{2'd0, 0, 5, 2, 1, 0, 1, 0, 0, 0, 1};
    tv[5]  = '{2'd0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1};
    tv[6]  = '{2'd3, 1, 12, 2, 1, 1, 0, 0, 0, 1, 1};
    tv[7]  = '{2'd0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[8]  = '{2'd2, 0, 12, 4, 1, 0, 0, 0, 0, 1, 1};
    tv[9]  = '{2'd1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0};
    tv[10] = '{2'd0, 0, 9, 2, 0, 0, 0, 0, 0, 0, 0};

    bus.pkt_vld = 0; bus.pkt_stream_id = '0;
    bus.s_data = '0; bus.s_vld = 0; bus.s_last = 0;
    bus.cfg_we = 0; bus.cfg_clr = 0; bus.cfg_id = '0; bus.cfg_en = 0;
    bus.m_fired = 0; bus.res_rdy = 0;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("post_reset_pkt_rdy", bus.pkt_rdy, 1);
    @(negedge clk);

    foreach (tv[i]) run_pkt(tv[i]);

    // reset while streaming: no result, tables wiped
    bus.pkt_vld = 1'b1;
    bus.pkt_stream_id = 6'd5;
    @(negedge clk);
    bus.pkt_vld = 1'b0;
    bus.s_vld = 1'b1;
    bus.s_data = 8'h7a;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stream_s_rdy", bus.s_rdy, 1);
    rst_n = 1'b0;
    bus.s_vld = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    rst_n = 1'b1;
    cnt_m = 16'd0;
    #1;
    chk("midrst_pkt_rdy", bus.pkt_rdy, 1);
    @(negedge clk);
    r = '{2'd0, 0, 5, 2, 1, 0, 0, 0, 0, 1, 0};
    run_pkt(r);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
